// File: rtl/acorn_absorb_seq.sv
`default_nettype none
// ============================================================================
//  Module      : acorn_absorb_seq
//  Description : W-lane ACORN absorb sequencer. Streams byte-aligned payload
//                (associated data or message) to a W-step state-update core,
//                appends the 1-then-255-zeros padding and produces the ca/cb
//                control bits for every step.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module acorn_absorb_seq #(
    parameter int W     = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] len_bits,
    input  logic [W-1:0]     s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [W-1:0]     step_m,
    output logic [W-1:0]     step_ca,
    output logic [W-1:0]     step_cb,
    output logic             step_valid,
    input  logic             step_ready,
    output logic             busy,
    output logic             done
);

    localparam int c_LOG2W = (W == 1) ? 0 : (W == 2) ? 1 : (W == 4) ? 2 : 3;
    localparam int c_CNT_W = LEN_W - c_LOG2W + 1;

    // Pad phase is 256 steps; ca stays high for the first 128 of them.
    localparam logic [c_CNT_W-1:0] c_PAD_INIT = c_CNT_W'(256 / W);
    localparam logic [c_CNT_W-1:0] c_CA_LIMIT = c_CNT_W'(128 / W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [W-1:0]       c_LANE0    = W'(1);

    // Only power-of-two lane counts that divide a byte are supported.
    generate
        if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
            $error("acorn_absorb_seq: W must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAD  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_mode;
    logic [c_CNT_W-1:0]   r_data_cnt;
    logic [c_CNT_W-1:0]   r_pad_cnt;

    logic                 w_step_valid;
    logic                 w_s_ready;
    logic [W-1:0]         w_m;
    logic [W-1:0]         w_ca;
    logic [W-1:0]         w_cb;
    logic                 w_step_fire;
    logic [c_CNT_W-1:0]   w_data_words;

    // Words of payload: len_bits is a byte multiple, so the shift is exact.
    assign w_data_words = c_CNT_W'({1'b0, len_bits} >> c_LOG2W);
    assign w_step_fire  = w_step_valid & step_ready;

    // Step word generation: payload pass-through in DATA, padding in PAD.
    always_comb begin
        w_step_valid = 1'b0;
        w_s_ready    = 1'b0;
        w_m          = '0;
        w_ca         = '0;
        w_cb         = '0;
        case (r_state)
            S_DATA: begin
                w_step_valid = s_valid;
                w_s_ready    = step_ready;
                w_m          = s_data;
                w_ca         = '1;
                w_cb         = {W{~r_mode}};
            end
            S_PAD: begin
                w_step_valid = 1'b1;
                w_m          = (r_pad_cnt == c_PAD_INIT) ? c_LANE0 : '0;
                w_ca         = (r_pad_cnt > c_CA_LIMIT) ? '1 : '0;
                w_cb         = {W{~r_mode}};
            end
            default: begin
            end
        endcase
    end

    // Pass sequencing: latch the request, count payload and pad words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_data_cnt <= '0;
            r_pad_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode     <= mode;
                        r_data_cnt <= w_data_words;
                        r_pad_cnt  <= c_PAD_INIT;
                        r_state    <= (len_bits != '0) ? S_DATA : S_PAD;
                    end
                end
                S_DATA: begin
                    if (w_step_fire) begin
                        r_data_cnt <= r_data_cnt - c_CNT_ONE;
                        if (r_data_cnt == c_CNT_ONE) begin
                            r_state <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    if (w_step_fire) begin
                        r_pad_cnt <= r_pad_cnt - c_CNT_ONE;
                        if (r_pad_cnt == c_CNT_ONE) begin
                            r_state <= S_FIN;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign step_valid = w_step_valid;
    assign s_ready    = w_s_ready;
    assign step_m     = w_m;
    assign step_ca    = w_ca;
    assign step_cb    = w_cb;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_acorn_absorb_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acorn_absorb_seq
//  Description : Self-checking bench for acorn_absorb_seq (W=8 and W=1
//                instances) against a step-index reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acorn_absorb_seq;

    logic        clk;
    logic        rst;
    logic        start8, start1;
    logic        mode;
    logic [15:0] len_bits;
    logic        s_valid;
    logic        step_ready;
    logic [7:0]  s_data8;
    logic        s_data1;

    logic        s_ready8, sv8, busy8, done8;
    logic [7:0]  m8, ca8, cb8;
    logic        s_ready1, sv1, busy1, done1;
    logic        m1, ca1, cb1;

    // Selected-instance view
    int          cur_w;
    logic        o_sready, o_sv, o_busy, o_done;
    logic [7:0]  o_m, o_ca, o_cb;

    int          n_vec;
    int          n_err;
    bit          pay [0:1023];

    acorn_absorb_seq #(.W(8), .LEN_W(16)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode), .len_bits(len_bits),
        .s_data(s_data8), .s_valid(s_valid), .s_ready(s_ready8),
        .step_m(m8), .step_ca(ca8), .step_cb(cb8), .step_valid(sv8),
        .step_ready(step_ready), .busy(busy8), .done(done8)
    );

    acorn_absorb_seq #(.W(1), .LEN_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode), .len_bits(len_bits),
        .s_data(s_data1), .s_valid(s_valid), .s_ready(s_ready1),
        .step_m(m1), .step_ca(ca1), .step_cb(cb1), .step_valid(sv1),
        .step_ready(step_ready), .busy(busy1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        o_sready = s_ready8;
        o_sv     = sv8;
        o_busy   = busy8;
        o_done   = done8;
        o_m      = m8;
        o_ca     = ca8;
        o_cb     = cb8;
        if (cur_w == 1) begin
            o_sready = s_ready1;
            o_sv     = sv1;
            o_busy   = busy1;
            o_done   = done1;
            o_m      = {7'b0, m1};
            o_ca     = {7'b0, ca1};
            o_cb     = {7'b0, cb1};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One complete pass on the selected instance, checked step by step.
    task automatic run_pass(input int w, input bit md, input int len, input bit stall, input bit poke);
        int         nstep, npay, ptr, total;
        bit         pstall, plast, seen_done, accepted;
        logic [7:0] pm, pca, pcb, em, eca, ecb;
        total = (len + 256) / w;
        for (int i = 0; i < len; i++) pay[i] = 1'($urandom_range(0, 1));
        cur_w = w;
        @(posedge clk) #1;
        mode = md;
        len_bits = 16'(len);
        if (w == 1) start1 = 1'b1; else start8 = 1'b1;
        s_valid = 1'b0;
        step_ready = 1'b0;
        @(posedge clk) #1;
        start8 = 1'b0;
        start1 = 1'b0;
        nstep = 0; npay = 0; ptr = 0;
        pstall = 1'b0; plast = 1'b0; seen_done = 1'b0; accepted = 1'b1;
        pm = '0; pca = '0; pcb = '0;
        for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
            // Drive: a late start must be ignored while busy
            if (poke && cyc == 4) begin
                if (w == 1) start1 = 1'b1; else start8 = 1'b1;
                mode = ~md;
                len_bits = 16'd8;
            end else begin
                start8 = 1'b0;
                start1 = 1'b0;
            end
            step_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (accepted || !s_valid)
                s_valid = (stall && ptr < len) ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int l = 0; l < 8; l++)
                s_data8[l] = (w == 8 && ptr + l < len) ? pay[ptr + l] : 1'b0;
            s_data1 = (w == 1 && ptr < len) ? pay[ptr] : 1'b0;
            @(negedge clk);
            check("busy_run", o_busy, 1);
            check("done_timing", o_done, plast);
            if (plast) seen_done = 1'b1;
            if (pstall) check("stall_hold", {o_sv, o_m, o_ca, o_cb}, {1'b1, pm, pca, pcb});
            if (ptr < len) check("sv_passthru", o_sv, s_valid);
            else           check("sready_low", o_sready, 0);
            accepted = s_valid & o_sready;
            if (accepted) begin
                npay++;
                ptr += w;
            end
            plast = 1'b0;
            if (o_sv && step_ready) begin
                em = '0; eca = '0; ecb = '0;
                for (int l = 0; l < w; l++) begin
                    int idx;
                    idx = nstep * w + l;
                    em[l]  = (idx < len) ? pay[idx] : (idx == len);
                    eca[l] = (idx < len + 128);
                    ecb[l] = ~md;
                end
                check("step_word", {o_m, o_ca, o_cb}, {em, eca, ecb});
                nstep++;
                if (nstep == total) plast = 1'b1;
            end
            pstall = o_sv & ~step_ready;
            pm = o_m; pca = o_ca; pcb = o_cb;
            @(posedge clk) #1;
        end
        start8 = 1'b0;
        start1 = 1'b0;
        s_valid = 1'b0;
        check("done_seen", seen_done, 1);
        check("step_count", nstep, total);
        check("pay_count", npay, len / w);
        @(negedge clk);
        check("busy_after", o_busy, 0);
        check("done_after", o_done, 0);
    endtask

    // Reset while DATA word 3 is being presented.
    task automatic reset_mid();
        cur_w = 8;
        @(posedge clk) #1;
        mode = 1'b0;
        len_bits = 16'd64;
        start8 = 1'b1;
        @(posedge clk) #1;
        start8 = 1'b0;
        s_valid = 1'b1;
        step_ready = 1'b1;
        s_data8 = 8'($urandom);
        repeat (3) @(posedge clk) #1;
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_sv", o_sv, 1);
        @(posedge clk) #1;
        rst = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_sv", o_sv, 0);
        check("rst_done", o_done, 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", o_done, 0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cur_w = 8;
        rst = 1'b1;
        start8 = 1'b0; start1 = 1'b0;
        mode = 1'b0; len_bits = '0;
        s_valid = 1'b0; step_ready = 1'b0;
        s_data8 = '0; s_data1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst8_ctl", {busy8, done8, sv8, s_ready8}, 0);
        check("rst8_step", {m8, ca8, cb8}, 0);
        check("rst1_all", {busy1, done1, sv1, s_ready1, m1, ca1, cb1}, 0);
        @(posedge clk) #1;
        rst = 1'b0;

        run_pass(8, 1'b0, 128, 1'b0, 1'b0);
        run_pass(8, 1'b1, 8,   1'b0, 1'b0);
        run_pass(8, 1'b0, 0,   1'b0, 1'b0);
        run_pass(8, 1'b0, 64,  1'b1, 1'b0);
        for (int r = 0; r < 4; r++)
            run_pass(8, 1'($urandom_range(0, 1)), 8 * $urandom_range(0, 16), 1'b1, 1'b0);
        run_pass(1, 1'b0, 8,  1'b0, 1'b0);
        run_pass(1, 1'b1, 16, 1'b1, 1'b0);
        reset_mid();
        run_pass(8, 1'b0, 64, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acorn_absorb_seq.md
Name: acorn_absorb_seq

Overview:
Parametrised successor to the bit-serial ACORN-128 associated-data loader. It streams a variable-length byte-aligned input (associated data or plaintext) through a valid/ready interface. It appends the ACORN padding (a single 1 followed by 255 zeros) and emits W state-update steps per clock, each step carrying an m bit and its ca and cb control bits. It sits between the input FIFO and a W-step-parallel state-update core; it holds no cipher state itself.

Parameters:
W, 8, steps per handshake (lanes); legal values 1, 2, 4, 8; elaboration error otherwise.
LEN_W, 16, width of the length field in bits; maximum payload is 2^LEN_W-8 bits.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a pass; honoured only in IDLE.
mode  in  1  0 = associated data (cb=1), 1 = message (cb=0); latched at start.
len_bits  in  LEN_W  payload length in bits; must be a multiple of 8; latched at start.
s_data  in  W  payload bits; s_data[0] is the earliest step.
s_valid  in  1  payload word valid.
s_ready  out  1  payload word accepted when s_valid & s_ready.
step_m  out  W  m bit per lane; lane 0 is the earliest step.
step_ca  out  W  ca per lane.
step_cb  out  W  cb per lane.
step_valid  out  1  step word valid.
step_ready  in  1  core consumes the step word when step_valid & step_ready.
busy  out  1  a pass is in progress.
done  out  1  one-cycle pulse, the cycle after the final pad word is accepted.

Behaviour:
- Reset (synchronous): FSM goes to IDLE and all counters clear. Outputs: busy=0, done=0, step_valid=0, s_ready=0, step_m/ca/cb=0.
- FSM states: IDLE, DATA, PAD, FIN.
- IDLE:
  - On start, latch mode and len_bits. Load data_cnt = len_bits/W and pad_cnt = 256/W.
  - Go to DATA if len_bits != 0, else to PAD.
  - start while not IDLE is ignored.
- DATA:
  - step_valid = s_valid; s_ready = step_ready. This is a combinational pass-through with zero latency; step_valid never depends on step_ready.
  - step_m = s_data; step_ca = all ones; step_cb = all (~mode_r).
  - Each accepted word decrements data_cnt. On acceptance of the word with data_cnt==1, go to PAD.
- PAD:
  - step_valid=1; s_ready=0, so extra payload is held upstream rather than consumed.
  - First pad word (pad_cnt==256/W): step_m lane 0 = 1, other lanes 0. All later pad words: step_m = 0.
  - step_ca = all ones while pad_cnt > 128/W, else 0. This makes ca=1 exactly for global step index < len_bits+128.
  - step_cb = all (~mode_r).
  - Each accepted word decrements pad_cnt. On acceptance with pad_cnt==1, go to FIN.
- FIN: done=1 for one cycle, step_valid=0, then go to IDLE.
- busy = (state != IDLE); it rises the cycle after start and falls in the cycle after FIN.
- Totals per pass:
  - Exactly len_bits/W + 256/W step handshakes.
  - Exactly len_bits/W payload handshakes.
  - Steps are never dropped or duplicated under arbitrary step_ready or s_valid stalls.
- Stall rule: step_m/ca/cb/step_valid stay stable while step_valid & ~step_ready. This holds in PAD by construction, and in DATA provided the upstream source holds s_data stable (AXI-style rule).
- Reset mid-pass: returns to IDLE the next cycle with no done pulse; partially consumed payload is discarded.
- start and rst in the same cycle: rst wins.
- Counters are sized to LEN_W-log2(W)+1 bits; no wrap is possible for legal len_bits.

Test Plan:
1. W=8, mode=0, len_bits=128, step_ready=1, s_valid=1 -> 48 step words.
   - Words 0-15 carry the payload with ca=0xFF, cb=0xFF.
   - Word 16 has m=0x01; words 16-31 have ca=0xFF; words 32-47 have m=0x00, ca=0x00.
   - done pulses once, the cycle after word 47.
2. W=8, mode=1, len_bits=8 -> 33 step words, all cb=0x00; ca=0xFF for words 0-16, 0x00 for words 17-32; word 1 has m=0x01.
3. W=8, len_bits=0 -> DATA is skipped and s_ready stays 0. 32 step words; word 0 has m=0x01; ca=0xFF for words 0-15; done after 32 handshakes.
4. W=8, len_bits=64, random step_ready and s_valid gaps (~50%) -> the step stream is identical to the no-stall run, with exactly 8 payload and 40 step handshakes; outputs are stable during stalls.
5. W=1, mode=0, len_bits=8 -> 264 steps; step 8 has m=1; ca=1 for steps 0-135 and 0 for steps 136-263; cb=1 throughout.
6. rst asserted during DATA word 3 -> next cycle busy=0, step_valid=0, no done. A new start then produces a clean full pass; start asserted while busy is ignored.
